jtdd_prom_we: RTL and testbench

- Download-side writer that feeds the game memories from the frontend byte stream.
- Sorts every incoming byte by address into one of two paths:
  - SDRAM ROM writes, packed as 16-bit words with a byte mask and a request/acknowledge handshake.
  - Priority-PROM loads, which drive the colour mixer's PROM write port (prog_addr / prom_prio_we / prom_din).
- Sits between the frontend download interface and both the SDRAM controller and the colour mixer.
- Signals completion so the game can be released from reset.

---
 rtl/jtdd_prom_we.sv | 192 +++++++++++++++++++
 tb/tb_jtdd_prom_we.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_prom_we.sv
// Download writer: routes frontend bytes to SDRAM (packed 16-bit words, req/ack)
// or to the priority PROM write port, and flags when the download has fully landed.
module jtdd_prom_we #(
  parameter logic [21:0] PRIO_START = 22'h0C_0000,
  parameter int unsigned PRIO_LEN   = 256,
  parameter int unsigned DLY        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic [7:0]  prom_din,
  output logic        prom_prio_we,
  output logic        dwn_done,
  output logic        ovf_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  localparam logic [22:0] PrioEnd = {1'b0, PRIO_START} + 23'(PRIO_LEN);
  localparam logic [1:0]  DlyLast = 2'(DLY - 1);

  state_e state_q, state_d;

  // FIFO entry layout: {mask[1:0], byte[7:0], word_addr[21:0]}
  logic [31:0] fifo_q [2];
  logic [31:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        hold_q, hold_d;
  logic [7:0]  hold_idx_q, hold_idx_d, hold_din_q, hold_din_d;
  logic [1:0]  dly_q, dly_d;

  logic [21:0] prog_addr_q, prog_addr_d;
  logic [15:0] prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d;
  logic        prog_we_q, prog_we_d;
  logic [7:0]  prom_din_q, prom_din_d;
  logic        prom_we_q, prom_we_d;
  logic        dwn_done_q, dwn_done_d;
  logic        ovf_q, ovf_d;

  logic        is_sd, is_prom, wr_sd, wr_prom, pop, push, slot_free;
  logic [7:0]  new_idx;
  logic [31:0] head;

  assign is_sd     = ioctl_addr < PRIO_START;
  assign is_prom   = !is_sd && ({1'b0, ioctl_addr} < PrioEnd);
  assign wr_sd     = downloading && ioctl_wr && is_sd;
  assign wr_prom   = downloading && ioctl_wr && is_prom;
  assign new_idx   = 8'(ioctl_addr - PRIO_START);
  assign pop       = prog_we_q && prog_ack;
  // A full FIFO still takes a byte on the cycle its head is acknowledged
  assign push      = wr_sd && ((cnt_q != 2'd2) || pop);
  // The shared port is free once no SDRAM request is outstanding past this edge
  // and any PROM pulse in flight is on its final cycle.
  assign slot_free = (!prog_we_q || prog_ack) && (!prom_we_q || dly_q == 2'd0);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + 2'(push) - 2'(pop);
    hold_d      = hold_q;
    hold_idx_d  = hold_idx_q;
    hold_din_d  = hold_din_q;
    dly_d       = dly_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_we_d   = prog_we_q;
    prom_din_d  = prom_din_q;
    prom_we_d   = prom_we_q;
    ovf_d       = ovf_q || (wr_sd && !push);

    if (push) begin
      fifo_d[wr_ptr_q] = {~ioctl_addr[0], ioctl_addr[0], ioctl_data, 1'b0, ioctl_addr[21:1]};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    if (prom_we_q) begin
      if (dly_q == 2'd0) prom_we_d = 1'b0;
      else               dly_d     = dly_q - 2'd1;
    end

    if (hold_q && slot_free) begin
      hold_d      = 1'b0;
      prom_we_d   = 1'b1;
      dly_d       = DlyLast;
      prog_addr_d = {14'd0, hold_idx_q};
      prom_din_d  = hold_din_q;
    end

    if (wr_prom) begin
      if (!hold_q && slot_free) begin
        prom_we_d   = 1'b1;
        dly_d       = DlyLast;
        prog_addr_d = {14'd0, new_idx};
        prom_din_d  = ioctl_data;
      end else if (!hold_q || slot_free) begin
        hold_d     = 1'b1;
        hold_idx_d = new_idx;
        hold_din_d = ioctl_data;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (pop) begin
      prog_we_d = 1'b0;
    end else if (!prog_we_q && cnt_q != 2'd0 && !prom_we_d) begin
      prog_we_d   = 1'b1;
      prog_addr_d = head[21:0];
      prog_data_d = {head[29:22], head[29:22]};
      prog_mask_d = head[31:30];
    end

    case (state_q)
      StIdle:  if (downloading) state_d = StLoad;
      StLoad:  if (!downloading) state_d = StDrain;
      StDrain: begin
        if (downloading) state_d = StLoad;
        else if (cnt_q == 2'd0 && !hold_q && !prog_we_q) state_d = StDone;
      end
      StDone:  if (downloading) state_d = StLoad;
      default: state_d = StIdle;
    endcase
    dwn_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      hold_q      <= 1'b0;
      hold_idx_q  <= 8'd0;
      hold_din_q  <= 8'd0;
      dly_q       <= 2'd0;
      prog_addr_q <= 22'd0;
      prog_data_q <= 16'd0;
      prog_mask_q <= 2'b11;
      prog_we_q   <= 1'b0;
      prom_din_q  <= 8'd0;
      prom_we_q   <= 1'b0;
      dwn_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_idx_q  <= hold_idx_d;
      hold_din_q  <= hold_din_d;
      dly_q       <= dly_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_we_q   <= prog_we_d;
      prom_din_q  <= prom_din_d;
      prom_we_q   <= prom_we_d;
      dwn_done_q  <= dwn_done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign prog_addr    = prog_addr_q;
  assign prog_data    = prog_data_q;
  assign prog_mask    = prog_mask_q;
  assign prog_we      = prog_we_q;
  assign prom_din     = prom_din_q;
  assign prom_prio_we = prom_we_q;
  assign dwn_done     = dwn_done_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_jtdd_prom_we.sv
// Bench for jtdd_prom_we: directed scenarios plus randomized bursts checked against
// per-path expected queues derived from the address classification rules.
module tb_jtdd_prom_we;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack = 1'b0;
  logic [7:0]  prom_din;
  logic        prom_prio_we;
  logic        dwn_done;
  logic        ovf_err;

  always #5 clk = ~clk;

  jtdd_prom_we dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we), .prog_ack(prog_ack),
    .prom_din(prom_din), .prom_prio_we(prom_prio_we), .dwn_done(dwn_done), .ovf_err(ovf_err)
  );

  typedef struct packed {logic [21:0] addr; logic [15:0] data; logic [1:0] mask;} sd_t;
  typedef struct packed {logic [7:0] idx; logic [7:0] din;} pr_t;

  localparam logic [21:0] PrioStart = 22'h0C0000;

  sd_t exp_sd[$], obs_sd[$];
  pr_t exp_pr[$], obs_pr[$];
  int  checks = 0, passed = 0;
  int  overlap = 0, hi_err = 0;
  bit  ack_en = 1'b0;
  int  ack_delay = 0;
  logic prev_we = 1'b0;

  // Request/write logger
  always @(negedge clk) begin
    if (prog_we && !prev_we) obs_sd.push_back({prog_addr, prog_data, prog_mask});
    prev_we = prog_we;
    if (prom_prio_we) begin
      obs_pr.push_back({prog_addr[7:0], prom_din});
      if (prog_addr[21:8] != 14'd0) hi_err++;
    end
    if (prom_prio_we && prog_we) overlap++;
  end

  // SDRAM controller stand-in: acknowledges each request ack_delay cycles after it rises
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!ack_en) wait_cnt = 0;
      else if (prog_ack) begin
        prog_ack = 1'b0;
        wait_cnt = 0;
      end else if (prog_we) begin
        if (wait_cnt >= ack_delay) prog_ack = 1'b1;
        else wait_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [21:0] a, input logic [7:0] d, input logic dl);
    logic [21:0] off;
    if (!dl) return;
    off = a - PrioStart;
    if (a < PrioStart) exp_sd.push_back({1'b0, a[21:1], d, d, ~a[0], a[0]});
    else if (a < PrioStart + 22'd256) exp_pr.push_back({off[7:0], d});
  endfunction

  task automatic send_byte(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    model(a, d, downloading);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic clear_q();
    exp_sd.delete(); obs_sd.delete(); exp_pr.delete(); obs_pr.delete();
  endtask

  task automatic do_reset();
    ack_en = 1'b0; prog_ack = 1'b0; ioctl_wr = 1'b0; downloading = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_q();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((obs_sd.size() < exp_sd.size() || obs_pr.size() < exp_pr.size() || prog_we ||
            prom_prio_we) && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    if (n >= budget) begin
      checks++;
      $display("FAIL wait_idle timeout: sd %0d/%0d pr %0d/%0d", obs_sd.size(), exp_sd.size(),
               obs_pr.size(), exp_pr.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (prog_mask !== 2'b11) $display("FAIL rst_mask got %b want 11", prog_mask); else passed++;
    checks++; if ({prog_we, prom_prio_we, dwn_done, ovf_err} !== 4'b0)
      $display("FAIL rst_flags got %b want 0000", {prog_we, prom_prio_we, dwn_done, ovf_err});
    else passed++;
    checks++; if (prog_addr !== 22'd0) $display("FAIL rst_addr got %h want 0", prog_addr); else passed++;
    downloading = 1'b1;
    tick();
    send_byte(22'h40, 8'h77);
    tick();
    checks++; if (prog_we !== 1'b1) $display("FAIL pre_rst_we got %b want 1", prog_we); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (prog_we !== 1'b0) $display("FAIL async_rst_we got %b want 0", prog_we); else passed++;
    checks++; if (prog_mask !== 2'b11) $display("FAIL async_rst_mask got %b want 11", prog_mask); else passed++;
    checks++; if (dwn_done !== 1'b0) $display("FAIL async_rst_done got %b want 0", dwn_done); else passed++;
    tick();
    rst_n = 1'b1;
    clear_q();
    ack_en = 1'b1;
    repeat (10) tick();
    checks++; if (obs_sd.size() != 0) $display("FAIL no_replay got %0d reqs want 0", obs_sd.size()); else passed++;
  endtask

  task automatic test_sdram();
    do_reset();
    downloading = 1'b1;
    tick();
    ack_en = 1'b1; ack_delay = 3;
    send_byte(22'h000010, 8'hA5);
    send_byte(22'h000011, 8'h3C);
    checks++; if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b1, 22'h8, 16'hA5A5, 2'b10})
      $display("FAIL sd_first got %b %h %h %b want 1 000008 a5a5 10", prog_we, prog_addr,
               prog_data, prog_mask);
    else passed++;
    wait_idle(100);
    checks++; if (obs_sd.size() != 2) $display("FAIL sd_pulses got %0d want 2", obs_sd.size()); else passed++;
    foreach (exp_sd[i]) if (i < obs_sd.size()) begin
      checks++; if (obs_sd[i] !== exp_sd[i]) $display("FAIL sd_req%0d got %h want %h", i, obs_sd[i], exp_sd[i]);
      else passed++;
    end
    checks++; if (ovf_err !== 1'b0) $display("FAIL sd_ovf got %b want 0", ovf_err); else passed++;
  endtask

  task automatic test_prom();
    do_reset();
    downloading = 1'b1;
    tick();
    ack_en = 1'b1; ack_delay = 1;
    send_byte(22'h0C0005, 8'h02);
    checks++; if ({prom_prio_we, prog_addr, prom_din, prog_we} !== {1'b1, 22'h5, 8'h02, 1'b0})
      $display("FAIL prom_wr got %b %h %h %b want 1 000005 02 0", prom_prio_we, prog_addr,
               prom_din, prog_we);
    else passed++;
    tick();
    checks++; if (prom_prio_we !== 1'b0) $display("FAIL prom_len got %b want 0", prom_prio_we); else passed++;
    send_byte(22'h0C0100, 8'h99);
    repeat (6) tick();
    checks++; if (obs_pr.size() != 1 || obs_sd.size() != 0)
      $display("FAIL prom_ignore got pr %0d sd %0d want 1 0", obs_pr.size(), obs_sd.size());
    else passed++;
    send_byte(22'h0C0000, 8'h11);
    repeat (3) tick();
    send_byte(22'h0C00FF, 8'h22);
    repeat (3) tick();
    send_byte(22'h0BFFFF, 8'h33);
    wait_idle(100);
    checks++; if (obs_pr.size() != exp_pr.size() || obs_sd.size() != exp_sd.size())
      $display("FAIL bound_cnt got pr %0d sd %0d want %0d %0d", obs_pr.size(), obs_sd.size(),
               exp_pr.size(), exp_sd.size());
    else passed++;
    foreach (exp_pr[i]) if (i < obs_pr.size()) begin
      checks++; if (obs_pr[i] !== exp_pr[i]) $display("FAIL bound_pr%0d got %h want %h", i, obs_pr[i], exp_pr[i]);
      else passed++;
    end
    foreach (exp_sd[i]) if (i < obs_sd.size()) begin
      checks++; if (obs_sd[i] !== exp_sd[i]) $display("FAIL bound_sd%0d got %h want %h", i, obs_sd[i], exp_sd[i]);
      else passed++;
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    downloading = 1'b1;
    tick();
    send_byte(22'h30, 8'($urandom));
    send_byte(22'h31, 8'($urandom));
    ioctl_addr = 22'h32; ioctl_data = 8'($urandom); ioctl_wr = 1'b1;
    model(ioctl_addr, ioctl_data, 1'b1);
    prog_ack = 1'b1;
    tick();
    ioctl_wr = 1'b0; prog_ack = 1'b0;
    checks++; if (ovf_err !== 1'b0) $display("FAIL full_pop_ovf got %b want 0", ovf_err); else passed++;
    ack_en = 1'b1; ack_delay = 0;
    wait_idle(100);
    checks++; if (obs_sd.size() != 3) $display("FAIL full_pop_cnt got %0d want 3", obs_sd.size()); else passed++;
    foreach (exp_sd[i]) if (i < obs_sd.size()) begin
      checks++; if (obs_sd[i] !== exp_sd[i]) $display("FAIL full_pop%0d got %h want %h", i, obs_sd[i], exp_sd[i]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 22'h20 + 22'(i); ioctl_data = 8'($urandom); ioctl_wr = 1'b1;
      if (i < 2) model(ioctl_addr, ioctl_data, 1'b1);
      tick();
      checks++; if (ovf_err !== (i >= 2)) $display("FAIL ovf_byte%0d got %b want %b", i, ovf_err, i >= 2);
      else passed++;
    end
    ioctl_wr = 1'b0;
    ack_en = 1'b1; ack_delay = $urandom_range(0, 3);
    wait_idle(100);
    checks++; if (obs_sd.size() != 2) $display("FAIL ovf_drain got %0d want 2", obs_sd.size()); else passed++;
    foreach (exp_sd[i]) if (i < obs_sd.size()) begin
      checks++; if (obs_sd[i] !== exp_sd[i]) $display("FAIL ovf_req%0d got %h want %h", i, obs_sd[i], exp_sd[i]);
      else passed++;
    end
    checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf_err); else passed++;
  endtask

  task automatic test_collision();
    logic [7:0] pidx;
    do_reset();
    downloading = 1'b1;
    tick();
    pidx = 8'($urandom);
    send_byte(22'h100, 8'($urandom));
    tick();
    checks++; if (prog_we !== 1'b1) $display("FAIL col_we got %b want 1", prog_we); else passed++;
    send_byte(22'h101, 8'($urandom));
    send_byte(PrioStart + 22'(pidx), 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      checks++; if ({prom_prio_we, prog_we} !== 2'b01)
        $display("FAIL col_wait%0d got prom %b we %b want 0 1", i, prom_prio_we, prog_we);
      else passed++;
      if (i < 2) tick();
    end
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    checks++; if ({prog_we, prom_prio_we, prog_addr, prom_din} !== {2'b01, 14'd0, exp_pr[0]})
      $display("FAIL col_prom got we %b prom %b %h %h want 0 1 %h", prog_we, prom_prio_we,
               prog_addr, prom_din, exp_pr[0]);
    else passed++;
    tick();
    checks++; if ({prom_prio_we, prog_we, prog_addr, prog_data, prog_mask} !== {2'b01, exp_sd[1]})
      $display("FAIL col_next got prom %b we %b %h %h %b want 0 1 %h", prom_prio_we, prog_we,
               prog_addr, prog_data, prog_mask, exp_sd[1]);
    else passed++;
    ack_en = 1'b1; ack_delay = 0;
    wait_idle(50);
    checks++; if (overlap != 0) $display("FAIL col_overlap got %0d want 0", overlap); else passed++;
  endtask

  task automatic test_completion();
    int n;
    do_reset();
    downloading = 1'b1;
    tick();
    send_byte(22'h200, 8'h5A);
    downloading = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (dwn_done !== 1'b0) $display("FAIL done_early%0d got %b want 0", i, dwn_done); else passed++;
      tick();
    end
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    n = 0;
    while (!dwn_done && n < 5) begin
      checks++; if (prog_we !== 1'b0) $display("FAIL done_we got %b want 0", prog_we); else passed++;
      tick();
      n++;
    end
    checks++; if (dwn_done !== 1'b1) $display("FAIL done_rise got %b want 1", dwn_done); else passed++;
    repeat (3) tick();
    checks++; if (dwn_done !== 1'b1) $display("FAIL done_hold got %b want 1", dwn_done); else passed++;
    downloading = 1'b1;
    tick();
    checks++; if (dwn_done !== 1'b0) $display("FAIL done_clear got %b want 0", dwn_done); else passed++;
  endtask

  task automatic test_random();
    logic [21:0] a;
    do_reset();
    downloading = 1'b1;
    tick();
    ack_en = 1'b1;
    overlap = 0; hi_err = 0;
    for (int b = 0; b < 40; b++) begin
      ack_delay = $urandom_range(0, 4);
      for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
        case ($urandom_range(0, 2))
          0: a = 22'($urandom_range(0, 32'h0BFFFF));
          1: a = PrioStart + 22'($urandom_range(0, 255));
          default: a = 22'($urandom_range(32'h0C0100, 32'h3FFFFF));
        endcase
        downloading = ($urandom_range(0, 5) != 0);
        send_byte(a, 8'($urandom));
        downloading = 1'b1;
      end
      wait_idle(200);
    end
    checks++; if (obs_sd.size() != exp_sd.size() || obs_pr.size() != exp_pr.size())
      $display("FAIL rnd_cnt got sd %0d pr %0d want %0d %0d", obs_sd.size(), obs_pr.size(),
               exp_sd.size(), exp_pr.size());
    else passed++;
    foreach (exp_sd[i]) if (i < obs_sd.size()) begin
      checks++; if (obs_sd[i] !== exp_sd[i]) $display("FAIL rnd_sd%0d got %h want %h", i, obs_sd[i], exp_sd[i]);
      else passed++;
    end
    foreach (exp_pr[i]) if (i < obs_pr.size()) begin
      checks++; if (obs_pr[i] !== exp_pr[i]) $display("FAIL rnd_pr%0d got %h want %h", i, obs_pr[i], exp_pr[i]);
      else passed++;
    end
    checks++; if ({ovf_err, overlap != 0, hi_err != 0} !== 3'b000)
      $display("FAIL rnd_flags got ovf %b overlap %0d hi %0d want 0 0 0", ovf_err, overlap, hi_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sdram();
    test_prom();
    test_full_pop();
    test_overflow();
    test_collision();
    test_completion();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
